// File: rtl/lfsr_rand_src_8.sv
// 8-bit Fibonacci LFSR word source with seed load, warm-up, decorrelation gap and valid/ready output.
// Optional feature: define LFSR_ENTROPY_MIX_EN to add entropy_in, XORed into the feedback during WARMUP and GAP steps.
module lfsr_rand_src_8 #(
   parameter int WARMUP_CYCLES = 16,
   parameter int STEP_GAP      = 8
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       seed_load,
   input  logic [7:0] seed_in,
   input  logic       start,
   input  logic       stop,
   input  logic       rand_ready,
`ifdef LFSR_ENTROPY_MIX_EN
   input  logic       entropy_in,
`endif
   output logic [7:0] rand_out,
   output logic       rand_valid,
   output logic       busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WARMUP = 2'd1;
   localparam logic [1:0] S_HOLD   = 2'd2;
   localparam logic [1:0] S_GAP    = 2'd3;

   // Reload values are clamped so illegal-but-harmless parameter corners still elaborate cleanly.
   localparam logic [7:0] WARM_LOAD = 8'((WARMUP_CYCLES > 0) ? (WARMUP_CYCLES - 1) : 0);
   localparam logic [7:0] GAP_LOAD  = 8'((STEP_GAP > 1) ? (STEP_GAP - 2) : 0);
   localparam logic       WARM_EN   = (WARMUP_CYCLES > 0);
   localparam logic       GAP_EN    = (STEP_GAP > 1);

   logic [1:0] state, state_n;
   logic [7:0] lfsr, lfsr_n;
   logic [7:0] cnt, cnt_n;
   logic       fb_base;
   logic [7:0] step_plain;
   logic [7:0] step_mix;

   assign fb_base    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign step_plain = {lfsr[6:0], fb_base};

`ifdef LFSR_ENTROPY_MIX_EN
   // Mixed feedback could hit the all-zero lockup state, so that one case is forced to 8'h01.
   logic [7:0] step_raw;
   assign step_raw = {lfsr[6:0], fb_base ^ entropy_in};
   assign step_mix = (step_raw == 8'h00) ? 8'h01 : step_raw;
`else
   assign step_mix = step_plain;
`endif

   always_comb begin
      state_n = state;
      lfsr_n  = lfsr;
      cnt_n   = cnt;
      if (seed_load) begin
         lfsr_n  = (seed_in == 8'h00) ? 8'h01 : seed_in;
         state_n = S_IDLE;
         cnt_n   = 8'h00;
      end else if (stop && (state != S_IDLE)) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (WARM_EN) begin
                     state_n = S_WARMUP;
                     cnt_n   = WARM_LOAD;
                  end else begin
                     state_n = S_HOLD;
                  end
               end
            end
            S_WARMUP: begin
               lfsr_n = step_mix;
               if (cnt == 8'h00) state_n = S_HOLD;
               else              cnt_n   = cnt - 8'h01;
            end
            S_HOLD: begin
               // The accepting step uses plain feedback; only WARMUP and GAP steps mix entropy.
               if (rand_ready) begin
                  lfsr_n = step_plain;
                  if (GAP_EN) begin
                     state_n = S_GAP;
                     cnt_n   = GAP_LOAD;
                  end
               end
            end
            default: begin
               lfsr_n = step_mix;
               if (cnt == 8'h00) state_n = S_HOLD;
               else              cnt_n   = cnt - 8'h01;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= S_IDLE;
         lfsr  <= 8'h01;
         cnt   <= 8'h00;
      end else begin
         state <= state_n;
         lfsr  <= lfsr_n;
         cnt   <= cnt_n;
      end
   end

   assign rand_out   = lfsr;
   assign rand_valid = (state == S_HOLD);
   assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_lfsr_rand_src_8.sv
// Scoreboard bench for lfsr_rand_src_8: three instances with different WARMUP/GAP settings.
// Stimulus pushes hand-computed expected words; monitors pop and compare on each accepted word.
module tb_lfsr_rand_src_8;

   logic clk;
   logic clr;

   logic       seed_load_a, start_a, stop_a, ready_a;
   logic [7:0] seed_in_a;
   logic [7:0] out_a;
   logic       valid_a, busy_a;

   logic       seed_load_b, start_b, stop_b, ready_b;
   logic [7:0] seed_in_b;
   logic [7:0] out_b;
   logic       valid_b, busy_b;

   logic       seed_load_c, start_c, stop_c, ready_c;
   logic [7:0] seed_in_c;
   logic [7:0] out_c;
   logic       valid_c, busy_c;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];

   lfsr_rand_src_8 #(.WARMUP_CYCLES(4), .STEP_GAP(1)) dut_a (
      .clk(clk), .clr(clr), .seed_load(seed_load_a), .seed_in(seed_in_a),
      .start(start_a), .stop(stop_a), .rand_ready(ready_a),
      .rand_out(out_a), .rand_valid(valid_a), .busy(busy_a));

   lfsr_rand_src_8 #(.WARMUP_CYCLES(0), .STEP_GAP(3)) dut_b (
      .clk(clk), .clr(clr), .seed_load(seed_load_b), .seed_in(seed_in_b),
      .start(start_b), .stop(stop_b), .rand_ready(ready_b),
      .rand_out(out_b), .rand_valid(valid_b), .busy(busy_b));

   lfsr_rand_src_8 #(.WARMUP_CYCLES(0), .STEP_GAP(1)) dut_c (
      .clk(clk), .clr(clr), .seed_load(seed_load_c), .seed_in(seed_in_c),
      .start(start_c), .stop(stop_c), .rand_ready(ready_c),
      .rand_out(out_c), .rand_valid(valid_c), .busy(busy_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%02h, required 0x%02h", name, act, req);
      end
   endtask

   // Advance n rising edges and settle just past the last one, away from the sampling edge.
   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #2;
   endtask

   // Monitors sample on the falling edge, midway between stimulus updates.
   always @(negedge clk) begin
      if (valid_a && ready_a) begin
         if (exp_a.size() == 0) checkOutput("a_unexpected_word", out_a, 8'hxx);
         else                   checkOutput("a_word", out_a, exp_a.pop_front());
      end
      if (valid_b && ready_b) begin
         if (exp_b.size() == 0) checkOutput("b_unexpected_word", out_b, 8'hxx);
         else                   checkOutput("b_word", out_b, exp_b.pop_front());
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rep_at;
      logic zero_seen;
      logic valid_dropped;

      clr = 1'b1;
      {seed_load_a, start_a, stop_a, ready_a} = '0; seed_in_a = 8'h00;
      {seed_load_b, start_b, stop_b, ready_b} = '0; seed_in_b = 8'h00;
      {seed_load_c, start_c, stop_c, ready_c} = '0; seed_in_c = 8'h00;

      // Reset, with start asserted during clr
      applyStimulus(1);
      start_a = 1'b1;
      applyStimulus(2);
      checkOutput("reset_out", out_a, 8'h01);
      checkOutput("reset_valid", {7'b0, valid_a}, 8'h00);
      checkOutput("reset_busy", {7'b0, busy_a}, 8'h00);
      checkOutput("reset_out_b", out_b, 8'h01);
      start_a = 1'b0;
      clr = 1'b0;
      applyStimulus(1);
      checkOutput("start_in_reset_ignored", {7'b0, busy_a}, 8'h00);

      // Warm-up on A: seed 01, start, expect 02,04,08,11
      seed_load_a = 1'b1; seed_in_a = 8'h01;
      applyStimulus(1);
      seed_load_a = 1'b0; start_a = 1'b1;
      applyStimulus(1);
      start_a = 1'b0;
      checkOutput("warm_busy", {7'b0, busy_a}, 8'h01);
      checkOutput("warm_valid_e0", {7'b0, valid_a}, 8'h00);
      applyStimulus(3);
      checkOutput("warm_valid_e3", {7'b0, valid_a}, 8'h00);
      checkOutput("warm_out_e3", out_a, 8'h08);
      applyStimulus(1);
      checkOutput("warm_valid_e4", {7'b0, valid_a}, 8'h01);
      checkOutput("warm_first_word", out_a, 8'h11);

      // Backpressure: word held without stepping
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1);
         checkOutput("bp_out", out_a, 8'h11);
         checkOutput("bp_valid", {7'b0, valid_a}, 8'h01);
      end

      exp_a.push_back(8'h11);
      exp_a.push_back(8'h23);
      ready_a = 1'b1;
      applyStimulus(2);
      ready_a = 1'b0;
      checkOutput("after_accept_out", out_a, 8'h47);
      checkOutput("after_accept_valid", {7'b0, valid_a}, 8'h01);

      // Zero seed replaced by 01, FSM back to IDLE
      seed_load_a = 1'b1; seed_in_a = 8'h00;
      applyStimulus(1);
      seed_load_a = 1'b0;
      checkOutput("zero_seed_out", out_a, 8'h01);
      checkOutput("zero_seed_busy", {7'b0, busy_a}, 8'h00);
      checkOutput("zero_seed_valid", {7'b0, valid_a}, 8'h00);

      // Stop during warm-up keeps the LFSR value
      start_a = 1'b1;
      applyStimulus(1);
      start_a = 1'b0;
      applyStimulus(2);
      checkOutput("pre_stop_out", out_a, 8'h04);
      stop_a = 1'b1;
      applyStimulus(1);
      stop_a = 1'b0;
      checkOutput("stop_busy", {7'b0, busy_a}, 8'h00);
      checkOutput("stop_out", out_a, 8'h04);
      applyStimulus(3);
      checkOutput("stop_hold_out", out_a, 8'h04);
      checkOutput("stop_hold_valid", {7'b0, valid_a}, 8'h00);

      // seed_load and stop together: seed wins
      start_a = 1'b1;
      applyStimulus(1);
      start_a = 1'b0;
      applyStimulus(1);
      checkOutput("pre_seedstop_out", out_a, 8'h08);
      seed_load_a = 1'b1; seed_in_a = 8'h5A; stop_a = 1'b1;
      applyStimulus(1);
      seed_load_a = 1'b0; stop_a = 1'b0;
      checkOutput("seedstop_out", out_a, 8'h5A);
      checkOutput("seedstop_busy", {7'b0, busy_a}, 8'h00);

      // Gap on B: WARMUP 0, STEP_GAP 3
      start_b = 1'b1;
      applyStimulus(1);
      start_b = 1'b0;
      checkOutput("gap_first_valid", {7'b0, valid_b}, 8'h01);
      checkOutput("gap_first_word", out_b, 8'h01);
      exp_b.push_back(8'h01);
      exp_b.push_back(8'h08);
      ready_b = 1'b1;
      applyStimulus(1);
      checkOutput("gap_low_1", {7'b0, valid_b}, 8'h00);
      applyStimulus(1);
      checkOutput("gap_low_2", {7'b0, valid_b}, 8'h00);
      applyStimulus(1);
      checkOutput("gap_second_valid", {7'b0, valid_b}, 8'h01);
      checkOutput("gap_second_word", out_b, 8'h08);
      applyStimulus(1);
      ready_b = 1'b0;
      checkOutput("gap_after_second_valid", {7'b0, valid_b}, 8'h00);

      // Period on C: free-run one word per cycle until 01 recurs
      start_c = 1'b1;
      applyStimulus(1);
      start_c = 1'b0;
      ready_c = 1'b1;
      checkOutput("period_first_word", out_c, 8'h01);
      rep_at = -1;
      zero_seen = 1'b0;
      valid_dropped = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         applyStimulus(1);
         if (out_c == 8'h00) zero_seen = 1'b1;
         if (!valid_c) valid_dropped = 1'b1;
         if (out_c == 8'h01 && rep_at < 0) rep_at = i;
      end
      ready_c = 1'b0;
      checkOutput("period_length", 8'(rep_at), 8'(255));
      checkOutput("period_no_zero", {7'b0, zero_seen}, 8'h00);
      checkOutput("period_valid_continuous", {7'b0, valid_dropped}, 8'h00);

      applyStimulus(2);
      checkOutput("a_queue_drained", 8'(exp_a.size()), 8'h00);
      checkOutput("b_queue_drained", 8'(exp_b.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
